// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, traps illegal encodings, counts retirements.
module multicycle_controller #(
  parameter bit          EXT_BRANCH = 1'b1,
  parameter bit          EXT_ALU    = 1'b1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          Instr,
  input  logic                 Zero,
  input  logic                 Negative,
  input  logic                 Overflow,
  input  logic                 Carry,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 MemReq,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [3:0]           ALUControl,
  output logic                 Illegal,
  output logic [CNT_WIDTH-1:0] InstRet
);

  localparam int unsigned OPW = 7;
  localparam int unsigned ALUW = 4;
  localparam int unsigned IMMW = 3;

  localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPW-1:0] OP_R      = 7'b0110011;
  localparam logic [OPW-1:0] OP_I      = 7'b0010011;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUW-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALUW-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALUW-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALUW-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUW-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALUW-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALUW-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALUW-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALUW-1:0] ALU_SLTU = 4'b1001;

  localparam logic [IMMW-1:0] IMM_I = 3'b000;
  localparam logic [IMMW-1:0] IMM_S = 3'b001;
  localparam logic [IMMW-1:0] IMM_B = 3'b010;
  localparam logic [IMMW-1:0] IMM_J = 3'b011;
  localparam logic [IMMW-1:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  state_t               w_dec_state;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [OPW-1:0]       w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic                 w_alu_f3_ok;
  logic                 w_r_legal;
  logic                 w_br_legal;
  logic                 w_taken;
  logic [ALUW-1:0]      w_alu_op;
  logic [IMMW-1:0]      w_imm_src;
  logic                 w_pc_we;
  logic                 w_ir_we;
  logic                 w_reg_we;
  logic                 w_mem_we;
  logic                 w_mem_req;
  logic                 w_unused_fields;

  assign w_opcode        = Instr[6:0];
  assign w_funct3        = Instr[14:12];
  assign w_funct7        = Instr[31:25];
  assign w_unused_fields = ^Instr[24:7];

  // Instruction legality and DECODE successor
  always_comb begin
    w_alu_f3_ok = EXT_ALU || !(w_funct3 inside {3'b001, 3'b011, 3'b100, 3'b101});
    w_r_legal   = w_alu_f3_ok &&
                  ((w_funct7 == 7'b0000000) ||
                   ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
    w_br_legal  = (w_funct3 == 3'b000) ||
                  (EXT_BRANCH && (w_funct3 inside {3'b001, 3'b100, 3'b101, 3'b110, 3'b111}));
    w_dec_state = S_TRAP;
    case (w_opcode)
      OP_LOAD, OP_STORE: w_dec_state = (w_funct3 == 3'b010) ? S_MEMADR : S_TRAP;
      OP_R:              w_dec_state = w_r_legal ? S_EXECR : S_TRAP;
      OP_I:              w_dec_state = w_alu_f3_ok ? S_EXECI : S_TRAP;
      OP_BRANCH:         w_dec_state = w_br_legal ? S_BRANCH : S_TRAP;
      OP_JAL:            w_dec_state = S_JAL;
      OP_JALR:           w_dec_state = (w_funct3 == 3'b000) ? S_JALR : S_TRAP;
      OP_LUI:            w_dec_state = S_LUI;
      OP_AUIPC:          w_dec_state = S_ALUWB;
      default:           w_dec_state = S_TRAP;
    endcase
  end

  // ALU operation, branch condition and immediate format
  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_op = ((w_opcode == OP_R) && w_funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase

    case (w_funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = !Zero;
      3'b100:  w_taken = Negative ^ Overflow;
      3'b101:  w_taken = !(Negative ^ Overflow);
      3'b110:  w_taken = !Carry;
      3'b111:  w_taken = Carry;
      default: w_taken = 1'b0;
    endcase

    case (w_opcode)
      OP_STORE:          w_imm_src = IMM_S;
      OP_BRANCH:         w_imm_src = IMM_B;
      OP_JAL:            w_imm_src = IMM_J;
      OP_LUI, OP_AUIPC:  w_imm_src = IMM_U;
      default:           w_imm_src = IMM_I;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next state and datapath controls
  always_comb begin
    w_next     = r_state;
    w_pc_we    = 1'b0;
    w_ir_we    = 1'b0;
    w_reg_we   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_req  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = w_imm_src;
    ALUControl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (MemReady) begin
          w_ir_we   = 1'b1;
          w_pc_we   = 1'b1;
          ResultSrc = 2'b10;
          ALUSrcB   = 2'b10;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        w_next  = w_dec_state;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        AdrSrc    = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        AdrSrc    = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_reg_we  = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_op;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_op;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_we = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        w_pc_we    = w_taken;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pc_we = 1'b1;
        w_next  = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_I;
        w_next  = S_JAL;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
        w_next  = S_ALUWB;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are forced low for the whole reset interval, not just after the edge
  assign PCWrite  = w_pc_we & rst_n;
  assign IRWrite  = w_ir_we & rst_n;
  assign RegWrite = w_reg_we & rst_n;
  assign MemWrite = w_mem_we & rst_n;
  assign MemReq   = w_mem_req & rst_n;
  assign Illegal  = (r_state == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_instret <= '0;
    else if ((r_state != S_FETCH) && (w_next == S_FETCH)) r_instret <= r_instret + CNT_WIDTH'(1);
  end

  assign InstRet = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default build plus a reduced build
// (no extended branches/ALU ops, 4-bit retire counter).
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n1, MemReady, MemReady1;
  logic [31:0] Instr, Instr1;
  logic        Zero, Negative, Overflow, Carry;

  logic        PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] InstRet;

  logic        PCWrite1, IRWrite1, RegWrite1, MemWrite1, MemReq1, AdrSrc1, Illegal1;
  logic [1:0]  ResultSrc1, ALUSrcA1, ALUSrcB1;
  logic [2:0]  ImmSrc1;
  logic [3:0]  ALUControl1;
  logic [3:0]  InstRet1;

  logic [19:0] obs0, obs1;
  assign obs0 = {PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
  assign obs1 = {PCWrite1, IRWrite1, RegWrite1, MemWrite1, MemReq1, AdrSrc1,
                 ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1, ALUControl1, Illegal1};

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Carry(Carry), .MemReady(MemReady), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemReq(MemReq),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal), .InstRet(InstRet)
  );

  multicycle_controller #(.EXT_BRANCH(1'b0), .EXT_ALU(1'b0), .CNT_WIDTH(4)) dut_min (
    .clk(clk), .rst_n(rst_n1), .Instr(Instr1), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Carry(Carry), .MemReady(MemReady1), .PCWrite(PCWrite1),
    .IRWrite(IRWrite1), .RegWrite(RegWrite1), .MemWrite(MemWrite1), .MemReq(MemReq1),
    .AdrSrc(AdrSrc1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
    .ImmSrc(ImmSrc1), .ALUControl(ALUControl1), .Illegal(Illegal1), .InstRet(InstRet1)
  );

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_SLTU  = 32'h0020B1B3;
  localparam logic [31:0] I_XORI  = 32'hFFF0C093;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BLT   = 32'h0020C063;
  localparam logic [31:0] I_JALR  = 32'h000280E7;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
  localparam logic [31:0] I_XOR   = 32'h0020C1B3;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_SLT   = 32'h0020A1B3;
  localparam logic [31:0] I_ADDI  = 32'h00108093;

  localparam logic [5:0] EN_0  = 6'b000000;
  localparam logic [5:0] EN_FW = 6'b000010;
  localparam logic [5:0] EN_FR = 6'b110010;
  localparam logic [5:0] EN_RW = 6'b001000;
  localparam logic [5:0] EN_MR = 6'b000011;
  localparam logic [5:0] EN_MW = 6'b000111;
  localparam logic [5:0] EN_PC = 6'b100000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;

  int n_checks = 0;
  int n_fail   = 0;

  // Fields: {PCWrite,IRWrite,RegWrite,MemWrite,MemReq,AdrSrc}, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  function automatic logic [19:0] ev(input logic [5:0] en, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ill);
    return {en, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [19:0] e_fr(input logic [2:0] imm);
    return ev(EN_FR, 2'b10, 2'b00, 2'b10, imm, A_ADD, 1'b0);
  endfunction
  function automatic logic [19:0] e_fw(input logic [2:0] imm);
    return ev(EN_FW, 2'b00, 2'b00, 2'b00, imm, A_ADD, 1'b0);
  endfunction
  function automatic logic [19:0] e_dec(input logic [2:0] imm);
    return ev(EN_0, 2'b00, 2'b01, 2'b01, imm, A_ADD, 1'b0);
  endfunction
  function automatic logic [19:0] e_wb(input logic [2:0] imm);
    return ev(EN_RW, 2'b00, 2'b00, 2'b00, imm, A_ADD, 1'b0);
  endfunction

  task automatic chkv(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ins, input logic is_r,
                         input logic [3:0] alu, input logic [31:0] cnt);
    Instr = ins; MemReady = 1'b1;
    #1 chkv($sformatf("%s_fetch", tag), obs0, e_fr(IMM_I)); nxt();
    #1 chkv($sformatf("%s_decode", tag), obs0, e_dec(IMM_I)); nxt();
    #1 chkv($sformatf("%s_exec", tag), obs0,
            ev(EN_0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01, IMM_I, alu, 1'b0)); nxt();
    #1 chkv($sformatf("%s_aluwb", tag), obs0, e_wb(IMM_I)); nxt();
    #1 chkn($sformatf("%s_instret", tag), InstRet, cnt);
  endtask

  initial begin
    rst_n = 1'b0; rst_n1 = 1'b0; Instr = '0; Instr1 = '0;
    MemReady = 1'b1; MemReady1 = 1'b0;
    Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0; Carry = 1'b0;
    #1;
    chkv("reset_outputs", obs0, ev(EN_0, 2'b10, 2'b00, 2'b10, IMM_I, A_ADD, 1'b0));
    chkn("reset_instret", InstRet, 32'd0);

    nxt(); rst_n = 1'b1;
    run_alu("add",  I_ADD,  1'b1, 4'b0000, 32'd1);
    run_alu("sub",  I_SUB,  1'b1, 4'b0001, 32'd2);
    run_alu("srai", I_SRAI, 1'b0, 4'b0111, 32'd3);
    run_alu("sltu", I_SLTU, 1'b1, 4'b1001, 32'd4);
    run_alu("xori", I_XORI, 1'b0, 4'b0100, 32'd5);

    // lw: 3 fetch waits, 2 memread waits
    Instr = I_LW; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chkv("lw_fetch_wait", obs0, e_fw(IMM_I)); nxt();
    end
    MemReady = 1'b1;
    #1 chkv("lw_fetch", obs0, e_fr(IMM_I)); nxt();
    #1 chkv("lw_decode", obs0, e_dec(IMM_I)); nxt();
    #1 chkv("lw_memadr", obs0, ev(EN_0, 2'b00, 2'b10, 2'b01, IMM_I, A_ADD, 1'b0)); nxt();
    MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chkv("lw_memread_wait", obs0, ev(EN_MR, 2'b00, 2'b00, 2'b00, IMM_I, A_ADD, 1'b0)); nxt();
    end
    MemReady = 1'b1;
    #1 chkv("lw_memread", obs0, ev(EN_MR, 2'b00, 2'b00, 2'b00, IMM_I, A_ADD, 1'b0)); nxt();
    #1 chkv("lw_memwb", obs0, ev(EN_RW, 2'b01, 2'b00, 2'b00, IMM_I, A_ADD, 1'b0)); nxt();
    #1 chkn("lw_instret", InstRet, 32'd6);

    Instr = I_SW;
    #1 chkv("sw_fetch", obs0, e_fr(IMM_S)); nxt();
    #1 chkv("sw_decode", obs0, e_dec(IMM_S)); nxt();
    #1 chkv("sw_memadr", obs0, ev(EN_0, 2'b00, 2'b10, 2'b01, IMM_S, A_ADD, 1'b0)); nxt();
    MemReady = 1'b0;
    #1 chkv("sw_memwrite_wait", obs0, ev(EN_MW, 2'b00, 2'b00, 2'b00, IMM_S, A_ADD, 1'b0)); nxt();
    MemReady = 1'b1;
    #1 chkv("sw_memwrite", obs0, ev(EN_MW, 2'b00, 2'b00, 2'b00, IMM_S, A_ADD, 1'b0)); nxt();
    #1 chkn("sw_instret", InstRet, 32'd7);

    Instr = I_BLT;
    #1 chkv("blt_fetch", obs0, e_fr(IMM_B)); nxt();
    #1 chkv("blt_decode", obs0, e_dec(IMM_B)); nxt();
    Negative = 1'b1; Overflow = 1'b0;
    #1 chkv("blt_taken", obs0, ev(EN_PC, 2'b00, 2'b10, 2'b00, IMM_B, A_SUB, 1'b0));
    Overflow = 1'b1;
    #1 chkv("blt_not_taken", obs0, ev(EN_0, 2'b00, 2'b10, 2'b00, IMM_B, A_SUB, 1'b0)); nxt();
    Negative = 1'b0; Overflow = 1'b0;
    #1 chkn("blt_instret", InstRet, 32'd8);

    Instr = I_JALR;
    #1 chkv("jalr_fetch", obs0, e_fr(IMM_I)); nxt();
    #1 chkv("jalr_decode", obs0, e_dec(IMM_I)); nxt();
    #1 chkv("jalr_jalr", obs0, ev(EN_0, 2'b00, 2'b10, 2'b01, IMM_I, A_ADD, 1'b0)); nxt();
    #1 chkv("jalr_jal", obs0, ev(EN_PC, 2'b00, 2'b01, 2'b10, IMM_I, A_ADD, 1'b0)); nxt();
    #1 chkv("jalr_aluwb", obs0, e_wb(IMM_I)); nxt();
    #1 chkn("jalr_instret", InstRet, 32'd9);

    Instr = I_LUI;
    #1 chkv("lui_fetch", obs0, e_fr(IMM_U)); nxt();
    #1 chkv("lui_decode", obs0, e_dec(IMM_U)); nxt();
    #1 chkv("lui_lui", obs0, ev(EN_0, 2'b00, 2'b11, 2'b01, IMM_U, A_ADD, 1'b0)); nxt();
    #1 chkv("lui_aluwb", obs0, e_wb(IMM_U)); nxt();
    #1 chkn("lui_instret", InstRet, 32'd10);

    Instr = I_AUIPC;
    #1 chkv("auipc_fetch", obs0, e_fr(IMM_U)); nxt();
    #1 chkv("auipc_decode", obs0, e_dec(IMM_U)); nxt();
    #1 chkv("auipc_aluwb", obs0, e_wb(IMM_U)); nxt();
    #1 chkn("auipc_instret", InstRet, 32'd11);

    Instr = I_JAL;
    #1 chkv("jal_fetch", obs0, e_fr(IMM_J)); nxt();
    #1 chkv("jal_decode", obs0, e_dec(IMM_J)); nxt();
    #1 chkv("jal_jal", obs0, ev(EN_PC, 2'b00, 2'b01, 2'b10, IMM_J, A_ADD, 1'b0)); nxt();
    #1 chkv("jal_aluwb", obs0, e_wb(IMM_J)); nxt();
    #1 chkn("jal_instret", InstRet, 32'd12);

    Instr = I_BAD;
    #1 chkv("bad_fetch", obs0, e_fr(IMM_I)); nxt();
    #1 chkv("bad_decode", obs0, e_dec(IMM_I)); nxt();
    for (int i = 0; i < 100; i++) begin
      #1 chkv("trap_hold", obs0, ev(EN_0, 2'b00, 2'b00, 2'b00, IMM_I, A_ADD, 1'b1));
      chkn("trap_instret", InstRet, 32'd12);
      nxt();
    end
    rst_n = 1'b0;
    #1 chkv("trap_reset", obs0, ev(EN_0, 2'b10, 2'b00, 2'b10, IMM_I, A_ADD, 1'b0));
    chkn("trap_reset_instret", InstRet, 32'd0);
    nxt(); rst_n = 1'b1;

    // Reset while a store is waiting on memory
    Instr = I_SW; MemReady = 1'b1;
    #1 chkv("swr_fetch", obs0, e_fr(IMM_S)); nxt();
    #1 chkv("swr_decode", obs0, e_dec(IMM_S)); nxt();
    MemReady = 1'b0;
    #1 chkv("swr_memadr", obs0, ev(EN_0, 2'b00, 2'b10, 2'b01, IMM_S, A_ADD, 1'b0)); nxt();
    #1 chkv("swr_memwrite", obs0, ev(EN_MW, 2'b00, 2'b00, 2'b00, IMM_S, A_ADD, 1'b0));
    rst_n = 1'b0;
    #1 chkv("swr_async_drop", obs0, ev(EN_0, 2'b00, 2'b00, 2'b00, IMM_S, A_ADD, 1'b0));
    chkn("swr_instret", InstRet, 32'd0);
    nxt(); rst_n = 1'b1;

    // Reduced build
    rst_n1 = 1'b1; Instr1 = I_BLT; MemReady1 = 1'b1;
    #1 chkv("min_blt_fetch", obs1, e_fr(IMM_B)); nxt();
    #1 chkv("min_blt_decode", obs1, e_dec(IMM_B)); nxt();
    #1 chkv("min_blt_trap", obs1, ev(EN_0, 2'b00, 2'b00, 2'b00, IMM_B, A_ADD, 1'b1)); nxt();
    #1 chkv("min_blt_trap_hold", obs1, ev(EN_0, 2'b00, 2'b00, 2'b00, IMM_B, A_ADD, 1'b1));
    chkn("min_blt_instret", 32'(InstRet1), 32'd0);
    rst_n1 = 1'b0;
    #1 chkv("min_trap_reset", obs1, ev(EN_0, 2'b10, 2'b00, 2'b10, IMM_B, A_ADD, 1'b0));
    nxt(); rst_n1 = 1'b1; Instr1 = I_XOR;
    #1 chkv("min_xor_fetch", obs1, e_fr(IMM_I)); nxt();
    #1 chkv("min_xor_decode", obs1, e_dec(IMM_I)); nxt();
    #1 chkv("min_xor_trap", obs1, ev(EN_0, 2'b00, 2'b00, 2'b00, IMM_I, A_ADD, 1'b1));
    rst_n1 = 1'b0;
    nxt(); rst_n1 = 1'b1; Instr1 = I_BEQ; Zero = 1'b1;
    #1 chkv("min_beq_fetch", obs1, e_fr(IMM_B)); nxt();
    #1 chkv("min_beq_decode", obs1, e_dec(IMM_B)); nxt();
    #1 chkv("min_beq_taken", obs1, ev(EN_PC, 2'b00, 2'b10, 2'b00, IMM_B, A_SUB, 1'b0)); nxt();
    Zero = 1'b0;
    #1 chkn("min_beq_instret", 32'(InstRet1), 32'd1);
    Instr1 = I_SLT;
    #1 chkv("min_slt_fetch", obs1, e_fr(IMM_I)); nxt();
    #1 chkv("min_slt_decode", obs1, e_dec(IMM_I)); nxt();
    #1 chkv("min_slt_exec", obs1, ev(EN_0, 2'b00, 2'b10, 2'b00, IMM_I, 4'b1000, 1'b0)); nxt();
    #1 chkv("min_slt_aluwb", obs1, e_wb(IMM_I)); nxt();
    #1 chkn("min_slt_instret", 32'(InstRet1), 32'd2);

    rst_n1 = 1'b0;
    nxt(); rst_n1 = 1'b1; Instr1 = I_ADDI;
    for (int i = 0; i < 16; i++) repeat (4) nxt();
    #1 chkn("min_wrap16", 32'(InstRet1), 32'd0);
    repeat (4) nxt();
    #1 chkn("min_wrap17", 32'(InstRet1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
